// File: rtl/tri_bus_arbiter.sv
// Round-robin owner arbiter for a shared tri-state bus with a dead turnaround window between owners.
// Optional hold-timeout feature: define TIMEOUT_EN to enable forced release after MAX_HOLD cycles.
module tri_bus_arbiter #(
  parameter int N        = 4,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [N-1:0] drv_en,
  output logic [2:0]   owner,
  output logic         busy,
  output logic         timeout
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  if (N < 2 || N > 8 || TURN_CYC < 1 || TURN_CYC > 15 || MAX_HOLD < 1) begin : g_bad_param
    $error("tri_bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [2:0]     owner_q, owner_d;
  logic [2:0]     last_q, last_d;
  logic [3:0]     turn_q, turn_d;
  logic [N-1:0]   elig;
  logic           win_vld;
  logic [2:0]     win;
  logic           arb, rel;
  int             idx;

`ifdef TIMEOUT_EN
  logic [HW-1:0]  hold_q, hold_d;
  logic [N-1:0]   mask_q, mask_d;
  logic           timeout_q, timeout_d;
  assign elig    = req & ~mask_q;
  assign timeout = timeout_q;
`else
  assign elig    = req;
  assign timeout = 1'b0;
`endif

  // Search starts just after the previous winner so the last owner ranks lowest.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    idx     = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last_q) + i) % N;
      if (!win_vld && elig[idx[IW-1:0]]) begin
        win_vld = 1'b1;
        win     = 3'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    turn_d  = turn_q;
    arb     = 1'b0;
    rel     = 1'b0;
`ifdef TIMEOUT_EN
    hold_d    = hold_q;
    mask_d    = mask_q & req;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE:  arb = 1'b1;
      GRANT: begin
        rel = !req[owner_q[IW-1:0]];
`ifdef TIMEOUT_EN
        hold_d = hold_q + 1'b1;
        if (!rel && hold_q == HW'(MAX_HOLD - 1)) begin
          rel                        = 1'b1;
          timeout_d                  = 1'b1;
          mask_d[owner_q[IW-1:0]]    = 1'b1;
        end
`endif
        if (rel) begin
          state_d = TURN;
          gnt_d   = '0;
          turn_d  = 4'(TURN_CYC - 1);
        end
      end
      TURN: begin
        // The last dead cycle doubles as the arbitration cycle.
        if (turn_q == '0) arb = 1'b1;
        else              turn_d = turn_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (arb) begin
      if (win_vld) begin
        state_d                = GRANT;
        gnt_d                  = '0;
        gnt_d[win[IW-1:0]]     = 1'b1;
        owner_d                = win;
        last_d                 = win;
`ifdef TIMEOUT_EN
        hold_d                 = '0;
`endif
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= 3'(N - 1);
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      turn_q  <= turn_d;
    end
  end

`ifdef TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q    <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  assign gnt    = gnt_q;
  assign drv_en = gnt_q;
  assign owner  = owner_q;
  assign busy   = (state_q == GRANT);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: two instances (TURN_CYC 1 and 3) against an ownership/quiet-gap model.
module tb_tri_bus_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt0, drv0, gnt1, drv1;
  logic [2:0]   own0, own1;
  logic         busy0, busy1, to0, to1;

  always #5 clk = ~clk;

  tri_bus_arbiter #(.N(N), .TURN_CYC(1), .MAX_HOLD(16)) u0 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt0), .drv_en(drv0),
    .owner(own0), .busy(busy0), .timeout(to0));

  tri_bus_arbiter #(.N(N), .TURN_CYC(3), .MAX_HOLD(16)) u1 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt1), .drv_en(drv1),
    .owner(own1), .busy(busy1), .timeout(to1));

  int n_chk = 0;
  int n_fail = 0;
  int m_own[2];
  int m_gap[2];
  int m_last[2];
  int turn_cyc[2] = '{1, 3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k]  = -1;
      m_gap[k]  = 0;
      m_last[k] = N - 1;
    end
  endtask

  // Model: an owner keeps the bus until its req is low at an edge; then
  // TURN_CYC quiet cycles, the last of which also picks the next owner.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (m_own[k] >= 0) begin
        if (!req[m_own[k]]) begin
          m_own[k] = -1;
          m_gap[k] = turn_cyc[k];
        end
      end else if (m_gap[k] > 1) begin
        m_gap[k]--;
      end else begin
        m_gap[k] = 0;
        for (int i = 1; i <= N; i++) begin
          int c;
          c = (m_last[k] + i) % N;
          if (m_own[k] < 0 && req[c]) begin
            m_own[k]  = c;
            m_last[k] = c;
          end
        end
      end
    end
  endtask

  function automatic logic [N-1:0] onehot(input int o);
    logic [N-1:0] v;
    v = '0;
    if (o >= 0) v[o] = 1'b1;
    return v;
  endfunction

  task automatic check_all();
    chk("gnt0", gnt0, onehot(m_own[0]));
    chk("drv0", drv0, onehot(m_own[0]));
    chk("busy0", busy0, m_own[0] >= 0);
    chk("to0", to0, 0);
    if (m_own[0] >= 0) chk("own0", own0, m_own[0]);
    chk("gnt1", gnt1, onehot(m_own[1]));
    chk("drv1", drv1, onehot(m_own[1]));
    chk("busy1", busy1, m_own[1] >= 0);
    chk("to1", to1, 0);
    if (m_own[1] >= 0) chk("own1", own1, m_own[1]);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int order[$];
  int gaps[$];
  int exp_rr[5] = '{0, 1, 2, 3, 0};
  int hold, zeros, held;
  logic [N-1:0] prev;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt0, 0);
    chk("rst_drv", drv0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_owner", own0, 0);
    chk("rst_timeout", to0, 0);
    @(negedge clk);
    rst = 1'b0;

    // single requester
    req = 4'b0100;
    cyc();
    chk("single_owner", own0, 2);
    chk("single_gnt", gnt0, 4'b0100);
    repeat (2) cyc();
    req = '0;
    cyc();
    chk("single_rel", gnt0, 0);
    repeat (4) cyc();

    // round-robin rotation, each owner drops req after 3 grant cycles
    do_reset();
    req = 4'b1111; hold = 0; zeros = 0; prev = '0;
    for (int t = 0; t < 60 && order.size() < 5; t++) begin
      cyc();
      if (gnt0 != '0 && gnt0 != prev) begin
        order.push_back(int'(own0));
        if (order.size() > 1) gaps.push_back(zeros);
        zeros = 0;
        hold  = 0;
      end
      if (gnt0 == '0) zeros++;
      else            hold++;
      prev = gnt0;
      req  = 4'b1111;
      if (gnt0 != '0 && hold == 3) req[own0[1:0]] = 1'b0;
    end
    chk("rr_count", order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++) chk("rr_order", order[i], exp_rr[i]);
    foreach (gaps[i]) chk("rr_gap", gaps[i], 1);
    req = '0;
    repeat (6) cyc();

    // asynchronous reset in the middle of a grant
    req = 4'b0010;
    repeat (2) cyc();
    chk("pre_rst_gnt0", gnt0, 4'b0010);
    chk("pre_rst_gnt1", gnt1, 4'b0010);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_gnt0", gnt0, 0);
    chk("arst_drv0", drv0, 0);
    chk("arst_gnt1", gnt1, 0);
    chk("arst_drv1", drv1, 0);
    @(negedge clk);
    rst = 1'b0;

    // requester 0 first after reset; 3-cycle turnaround on u1
    req = 4'b0011;
    cyc();
    chk("rst_prio0", own0, 0);
    chk("rst_prio1", own1, 0);
    repeat (2) cyc();
    req = 4'b0010;
    zeros = 0;
    for (int t = 0; t < 20 && gnt1 != 4'b0010; t++) begin
      cyc();
      if (gnt1 == '0) zeros++;
    end
    chk("turn_gap3", zeros, 3);
    chk("turn_next", gnt1, 4'b0010);

    // no timeout in this build: owner 1 keeps the bus while req stays high
    req = 4'b1010;
    held = 0;
    repeat (120) begin
      cyc();
      if (gnt0 == 4'b0010) held++;
    end
    chk("long_hold", held, 120);
    req = '0;
    repeat (5) cyc();

    // random traffic
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
